// File: rtl/rr_mux4_tx.sv
// rr_mux4_tx: four-channel round-robin serialiser with channel select and valid toward a 1-to-4 demux
module rr_mux4_tx #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         in_valid,
  output logic [3:0]         in_ready,
  input  logic [4*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_sel,
  output logic [WIDTH-1:0]   out_data
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t     state;
  logic [1:0] ptr;
  logic [1:0] grant;
  logic       load_ok;
  always_comb begin
    grant = ptr;
    for (int k = 3; k >= 0; k--) if (in_valid[ptr + 2'(k)]) grant = ptr + 2'(k);
  end
  assign load_ok   = (state == EMPTY) || out_ready;
  assign in_ready  = (rst_n && load_ok && |in_valid) ? 4'b0001 << grant : 4'b0000;
  assign out_valid = state == FULL;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      ptr      <= 2'd0;
      out_sel  <= 2'd0;
      out_data <= '0;
    end else if (|in_ready) begin
      state    <= FULL;
      ptr      <= grant + 2'd1;
      out_sel  <= grant;
      out_data <= in_data[grant*WIDTH +: WIDTH];
    end else if (out_ready) begin
      state <= EMPTY;
    end
  end
endmodule

// File: tb/tb_rr_mux4_tx.sv
// tb_rr_mux4_tx: directed scoreboard bench for the round-robin serialiser
module tb_rr_mux4_tx;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_sel;
  logic [7:0]  out_data;
  logic [3:0]  demux;
  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
  } word_t;
  word_t q[$];
  int nchk = 0;
  int npass = 0;
  rr_mux4_tx #(.WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sel(out_sel),
    .out_data(out_data)
  );
  always #5 clk = ~clk;
  assign demux = out_valid ? 4'b0001 << {out_sel[1], out_sel[0]} : 4'b0000;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic reset_cycles(input int n);
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready_comb", in_ready, 4'b0000);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      q.delete();
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_sel", out_sel, 2'd0);
      chk("rst_out_data", out_data, 8'd0);
      chk("rst_in_ready", in_ready, 4'b0000);
    end
    rst_n = 1'b1;
  endtask
  task automatic cyc(input logic [3:0] exp_rdy);
    word_t w;
    #1;
    chk("in_ready", in_ready, exp_rdy);
    if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
    for (int i = 0; i < 4; i++)
      if (exp_rdy[i] && in_valid[i]) begin
        w.sel  = 2'(i);
        w.data = in_data[i*8 +: 8];
        q.push_back(w);
      end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_sel", out_sel, q[0].sel);
      chk("out_data", out_data, q[0].data);
    end
  endtask
  initial begin
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    in_data   = 32'h13121110;
    reset_cycles(2);
    in_valid = 4'b0000;
    cyc(4'b0000);
    cyc(4'b0000);
    in_data   = 32'h00A50000;
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    cyc(4'b0100);
    in_valid = 4'b0000;
    cyc(4'b0000);
    in_valid = 4'b1111;
    reset_cycles(1);
    in_data = 32'h13121110;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) cyc(4'b0001 << i);
    in_valid = 4'b0000;
    cyc(4'b0000);
    in_data  = 32'h00003C00;
    in_valid = 4'b0010;
    cyc(4'b0010);
    in_data   = 32'h77000055;
    in_valid  = 4'b1001;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) cyc(4'b0000);
    out_ready = 1'b1;
    cyc(4'b1000);
    in_valid = 4'b0001;
    cyc(4'b0001);
    in_valid = 4'b0000;
    cyc(4'b0000);
    in_data  = 32'h00C00000;
    in_valid = 4'b0100;
    cyc(4'b0100);
    in_data  = 32'h0000B2B1;
    in_valid = 4'b0011;
    cyc(4'b0001);
    in_valid = 4'b0010;
    cyc(4'b0010);
    in_valid = 4'b0000;
    cyc(4'b0000);
    in_data   = 32'h00D00000;
    in_valid  = 4'b0100;
    out_ready = 1'b0;
    cyc(4'b0100);
    cyc(4'b0000);
    in_valid = 4'b0000;
    reset_cycles(1);
    chk("demux_idle", demux, 4'b0000);
    in_data   = 32'h13121110;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0001 << i);
      chk("demux", demux, 4'b0001 << i);
    end
    in_valid = 4'b0000;
    cyc(4'b0000);
    chk("demux_off", demux, 4'b0000);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
